// File: rtl/sample_delay_align_if.sv
// rtl/sample_delay_align_if.sv - sample stream and delay-control bundle for sample_delay_align
interface sample_delay_align_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
);
  logic [AW-1:0]    DELAY_TYPE;
  logic             Xin_VALID;
  logic [WIDTH-1:0] Xin;
  logic             Xout_VALID;
  logic [WIDTH-1:0] Xout;
  logic             FILLED;

  // Source side: drives samples and the requested delay, observes the delayed stream
  modport master (
    output DELAY_TYPE, Xin_VALID, Xin,
    input  Xout_VALID, Xout, FILLED
  );

  // Delay line side
  modport slave (
    input  DELAY_TYPE, Xin_VALID, Xin,
    output Xout_VALID, Xout, FILLED
  );
endinterface

// File: rtl/sample_delay_align.sv
// rtl/sample_delay_align.sv - programmable sample-count delay line (circular buffer realignment)
module sample_delay_align #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  sample_delay_align_if.slave bus
);

  localparam int DEPTH = 2 ** AW;

  // Buffer contents are don't-care after reset, so the array has no reset
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic [AW-1:0]    wr_ptr_q,     wr_ptr_d;
  logic [AW-1:0]    d_reg_q,      d_reg_d;
  logic [AW-1:0]    fill_q,       fill_d;
  logic [WIDTH-1:0] xout_q,       xout_d;
  logic             xout_valid_q, xout_valid_d;
  logic             filled_q,     filled_d;

  logic             changed;
  logic [AW-1:0]    rd_addr;
  logic [AW:0]      fill_inc;

  // Next-state: delay tracking, fill accounting and the registered output sample
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    d_reg_d      = d_reg_q;
    fill_d       = fill_q;
    xout_d       = xout_q;
    xout_valid_d = 1'b0;
    filled_d     = filled_q;

    changed  = (bus.DELAY_TYPE != d_reg_q);
    // Read address is taken from the pre-increment write pointer, so it points D samples back
    rd_addr  = wr_ptr_q - d_reg_q;
    fill_inc = {1'b0, fill_q} + (AW+1)'(bus.Xin_VALID);

    if (bus.Xin_VALID) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (changed) begin
      // New delay: restart fill; a sample arriving now is the first one under the new D
      d_reg_d  = bus.DELAY_TYPE;
      fill_d   = (bus.Xin_VALID && (bus.DELAY_TYPE != '0)) ? AW'(1) : '0;
      filled_d = 1'b0;
    end else begin
      filled_d = (fill_inc >= {1'b0, d_reg_q});
      fill_d   = (fill_inc > {1'b0, d_reg_q}) ? d_reg_q : fill_inc[AW-1:0];
      if (bus.Xin_VALID) begin
        if (d_reg_q == '0) begin
          xout_d       = bus.Xin;
          xout_valid_d = 1'b1;
        end else if (fill_q >= d_reg_q) begin
          xout_d       = mem[rd_addr];
          xout_valid_d = 1'b1;
        end
      end
    end
  end

  // Control and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      d_reg_q      <= '0;
      fill_q       <= '0;
      xout_q       <= '0;
      xout_valid_q <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      d_reg_q      <= d_reg_d;
      fill_q       <= fill_d;
      xout_q       <= xout_d;
      xout_valid_q <= xout_valid_d;
      filled_q     <= filled_d;
    end
  end

  // Sample buffer write; the async read above sees the old contents this cycle
  always_ff @(posedge CLK) begin
    if (bus.Xin_VALID) begin
      mem[wr_ptr_q] <= bus.Xin;
    end
  end

  assign bus.Xout       = xout_q;
  assign bus.Xout_VALID = xout_valid_q;
  assign bus.FILLED     = filled_q;

endmodule

// File: tb/tb_sample_delay_align.sv
// tb/tb_sample_delay_align.sv - randomized model-checked bench for sample_delay_align
module tb_sample_delay_align;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  sample_delay_align_if #(.WIDTH(16), .AW(6)) bus ();

  sample_delay_align #(.WIDTH(16), .AW(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: history of accepted samples plus a count of samples since the last delay change
  int          m_d;
  int          m_since;
  logic [15:0] hist[$];
  logic [15:0] m_xout;
  logic        m_ov;
  logic        m_filled;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d      = 0;
    m_since  = 0;
    hist.delete();
    m_xout   = '0;
    m_ov     = 1'b0;
    m_filled = 1'b0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] x, input int dt);
    if (dt != m_d) begin
      m_d      = dt;
      m_since  = v ? 1 : 0;
      m_ov     = 1'b0;
      m_filled = 1'b0;
    end else begin
      m_ov = 1'b0;
      if (v) begin
        if (m_d == 0) begin
          m_ov   = 1'b1;
          m_xout = x;
        end else if (m_since >= m_d) begin
          m_ov   = 1'b1;
          m_xout = hist[hist.size() - m_d];
        end
        m_since++;
      end
      m_filled = (m_since >= m_d);
    end
    if (v) begin
      hist.push_back(x);
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  task automatic step(input bit v, input logic [15:0] x, input int dt, input string tag);
    @(negedge CLK);
    bus.Xin_VALID  = v;
    bus.Xin        = x;
    bus.DELAY_TYPE = dt[5:0];
    @(posedge CLK);
    model_step(v, x, dt);
    #1;
    check_eq({tag, "_valid"},  32'(bus.Xout_VALID), 32'(m_ov));
    check_eq({tag, "_filled"}, 32'(bus.FILLED),     32'(m_filled));
    check_eq({tag, "_xout"},   32'(bus.Xout),       32'(m_xout));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rst_xout"},   32'(bus.Xout),       32'd0);
    check_eq({tag, "_rst_valid"},  32'(bus.Xout_VALID), 32'd0);
    check_eq({tag, "_rst_filled"}, 32'(bus.FILLED),     32'd0);
  endtask

  int cur_d;

  initial begin
    RST            = 1'b1;
    bus.Xin_VALID  = 1'b0;
    bus.Xin        = '0;
    bus.DELAY_TYPE = '0;
    model_reset();
    #12;
    check_reset_outputs("init");
    @(negedge CLK);
    RST = 1'b0;

    // Basic delay D=4 with a settle cycle before streaming
    step(1'b0, 16'd0, 4, "basic_chg");
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 16'(i), 4, "basic");
      check_eq("basic_filled_rule", 32'(bus.FILLED), (i >= 4) ? 32'd1 : 32'd0);
      if (i == 5) check_eq("basic_first_out", 32'(bus.Xout), 32'd1);
    end

    // Pass-through D=0, with one idle cycle in between
    step(1'b0, 16'd0, 0, "pass_chg");
    step(1'b1, 16'h8000, 0, "pass");
    step(1'b1, 16'h7FFF, 0, "pass");
    step(1'b0, 16'hDEAD, 0, "pass");
    step(1'b1, 16'h1234, 0, "pass");
    check_eq("pass_direct", 32'(bus.Xout), 32'h1234);

    // Gapped input at D=3
    step(1'b0, 16'd0, 3, "gap_chg");
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 16'(10 * i), 3, "gap");
      step(1'b0, 16'($urandom), 3, "gap_idle");
    end
    check_eq("gap_hold", 32'(bus.Xout), 32'd20);

    // Maximum delay across several pointer rollovers
    step(1'b0, 16'd0, 63, "max_chg");
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 16'(i), 63, "max");
      if (i >= 63) check_eq("max_direct", 32'(bus.Xout), 32'(i - 63));
    end

    // Delay change mid-stream: 2 -> 5
    for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h0100 + i), 2, "chg_a");
    for (int i = 0; i < 12; i++) step(1'b1, 16'(16'h0200 + i), 5, "chg_b");

    // Asynchronous reset in the middle of a D=8 stream
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 8, "ar_pre");
    @(negedge CLK);
    bus.Xin_VALID = 1'b0;
    #2 RST = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 16'(16'hA000 + i), 8, "ar_post");

    // Random traffic with occasional delay changes
    cur_d = 8;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cur_d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
      end
      step(($urandom_range(0, 3) != 0), 16'($urandom), cur_d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_delay_align.md
Name: sample_delay_align

Overview:
- Programmable sample-count delay line for the EMD datapath.
- Takes the input stream and re-emits each sample exactly D valid samples later, so the original signal lines up with the envelope-mean stream for residue computation.
- Circular buffer with write/read pointers, fill tracking and a valid strobe. This is the read-back/realignment counterpart of the shift-based delay stage.
- Sits between the sample source and the residue subtractor.

Parameters:
- WIDTH, 16, sample width in bits (two's complement, passed through unmodified).
- AW, 6, buffer address width; buffer depth 2^AW = 64 entries; maximum delay 2^AW-1 = 63 samples.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- DELAY_TYPE  input  AW  requested delay D in valid samples (0..63).
- Xin_VALID  input  1  qualifies Xin for one cycle.
- Xin  input  WIDTH  input sample.
- Xout_VALID  output  1  one-cycle strobe: Xout holds a delayed sample.
- Xout  output  WIDTH  delayed sample, registered.
- FILLED  output  1  high once D samples have been buffered under the current D.

Behaviour:
- Reset (async, RST=1): wr_ptr=0, fill=0, d_reg=0, Xout=0, Xout_VALID=0, FILLED=0. Buffer contents are don't-care. All outputs are held at reset values while RST=1. Leaving reset takes effect at the next rising edge.
- d_reg: registered copy of DELAY_TYPE, sampled every cycle.
  - If DELAY_TYPE != d_reg, then d_reg <= DELAY_TYPE, fill <= 0 and FILLED <= 0 (re-fill).
  - Any Xin_VALID in that same cycle is written to the buffer but counts as fill=1 under the new D. No output is produced that cycle.
- Write: when Xin_VALID=1, mem[wr_ptr] <= Xin and wr_ptr <= wr_ptr+1 (mod 2^AW, natural wrap).
- Read address: rd = wr_ptr - d_reg (mod 2^AW), computed before the write increments.
- D=0: pass-through. Xout <= Xin and Xout_VALID <= Xin_VALID. Latency 1 clock. FILLED=1 constantly except during the change cycle.
- D>0:
  - On Xin_VALID, Xout <= mem[rd]. The read uses old contents; the write to a different address is not visible.
  - Xout_VALID <= 1 only if fill >= D before this sample. Otherwise Xout_VALID <= 0 and Xout holds its previous value.
- Fill counter:
  - Increments on Xin_VALID and saturates at D.
  - FILLED <= (fill+Xin_VALID >= D).
- Latency: output sample k corresponds to input sample k-D. It appears 1 clock after the Xin_VALID that carries sample k.
- Xin_VALID=0: no pointer move, Xout_VALID <= 0, Xout holds.
- Gaps in Xin_VALID stretch the delay in clocks but not in samples.
- Wrap-around: pointer rollover from 63 to 0 is seamless; no sample is lost or duplicated at the rollover.
- Data is never modified: no saturation or rounding. Xout is bit-identical to the stored Xin.
- Implementation: single-port-write, async-read or registered-read memory. Registered read is permitted only if total latency is still exactly 1 clock from Xin_VALID to Xout_VALID.

Test Plan:
- Basic delay: RST pulse; D=4; feed Xin=1,2,3,... with Xin_VALID=1 every cycle -> Xout_VALID first high 1 clock after the 5th sample with Xout=1; then Xout=2,3,... each cycle; FILLED rises after the 4th sample.
- Pass-through: D=0; Xin=0x8000,0x7FFF,0x1234 -> Xout identical, 1 clock later; Xout_VALID mirrors Xin_VALID delayed by 1.
- Gapped input: D=3; Xin_VALID on alternate cycles with samples 10,20,30,40,50 -> outputs 10 then 20, each on the clock after samples 40 and 50; Xout_VALID low between them; Xout holds 10 through the gap.
- Max delay and wrap: D=63; stream 200 samples of incrementing value -> first valid output after sample 64 equals 0; output n equals n-63 across pointer rollovers at 64 and 128; no glitches.
- Delay change mid-stream: D=2 while streaming; switch to D=5 -> Xout_VALID low for the change cycle plus the next 4 samples; the first output after re-fill equals the sample written in the change cycle.
- Async reset mid-operation: assert RST asynchronously (between edges) while streaming with D=8 -> Xout=0, Xout_VALID=0 and FILLED=0 immediately; after release, 8 fresh samples are required before Xout_VALID; no stale pre-reset data appears.
